cacheline_adapter: RTL and testbench
====================================

Name: cacheline_adapter

Overview:
- Sits directly downstream of the 4-way set-associative cache's dfp port.
- Converts each 256-bit line read or line writeback into a 4-beat 64-bit burst on the burst-memory (bmem) interface.
- Read bursts are assembled into one line. Write lines are serialized into beats.
- Returns a single-cycle dfp_resp per completed line transaction.

Parameters:
- LINE_W, 256, cache line width in bits.
- BURST_W, 64, bmem beat width in bits.
- BEATS = LINE_W/BURST_W (4), localparam, beats per line; beat counter width is $clog2(BEATS).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- dfp_addr  in  32  line address from cache; bits [4:0] are ignored and forced to 0 outward.
- dfp_read  in  1  line read request, held high until dfp_resp.
- dfp_write  in  1  line write request, held high until dfp_resp.
- dfp_wdata  in  LINE_W  line to write, stable while dfp_write is high.
- dfp_rdata  out  LINE_W  assembled read line, valid when dfp_resp=1.
- dfp_resp  out  1  one-cycle completion pulse.
- bmem_addr  out  32  burst address, 32-byte aligned.
- bmem_read  out  1  one-cycle read command.
- bmem_write  out  1  write beat strobe.
- bmem_wdata  out  BURST_W  write beat data.
- bmem_ready  in  1  memory can accept a command this cycle.
- bmem_rdata  in  BURST_W  read beat data.
- bmem_rvalid  in  1  read beat valid.

Behaviour:
- Reset: state=IDLE, beat counter=0, line buffer=0; dfp_resp=0, bmem_read=0, bmem_write=0; bmem_addr=0, bmem_wdata=0, dfp_rdata=0.
- Reset mid-transaction aborts to IDLE. bmem_rvalid beats arriving in IDLE are ignored.
- Request capture (IDLE): on dfp_write or dfp_read, latch {dfp_addr[31:5],5'b0} into an address register.
  - On a write, also latch dfp_wdata into the line buffer.
  - If dfp_write and dfp_read are high together, write has priority; the read is re-sampled after dfp_resp.
  - IDLE -> WR_CMD (write) or RD_CMD (read).
- RD_CMD: bmem_addr=latched address, bmem_read=1 only while bmem_ready=1.
  - When bmem_ready=1, the command is accepted that cycle -> RD_DATA, counter=0.
  - If bmem_ready=0, hold in RD_CMD with bmem_read=0.
- RD_DATA: each cycle bmem_rvalid=1, store bmem_rdata into buffer[cnt*BURST_W +: BURST_W] and increment cnt.
  - Beat 0 maps to bits [63:0]; beat 3 maps to [255:192].
  - Gaps (rvalid=0) are permitted; cnt holds.
  - On the beat with cnt==BEATS-1 -> RESP.
- WR_CMD: bmem_addr=latched address, bmem_wdata=buffer[63:0], bmem_write=bmem_ready.
  - When bmem_ready=1, beat 0 is accepted -> WR_DATA, cnt=1.
- WR_DATA: bmem_write=1 and bmem_wdata=buffer[cnt*BURST_W +: BURST_W] on each of the 3 following consecutive cycles.
  - bmem_ready is not re-checked after beat 0.
  - After the cnt==BEATS-1 beat -> RESP.
  - The 4 write beats are on back-to-back cycles.
- RESP: dfp_resp=1 for exactly one cycle; dfp_rdata=buffer (held until next capture) -> IDLE.
  - A request high in the cycle after RESP is a new request; the writeback-then-allocate sequence issues a read immediately.
- Latency:
  - Read: dfp_resp at 1 (capture) + cmd wait + beat-arrival cycles + 1.
  - Write with bmem_ready=1: beats in cycles 1-4 after capture, dfp_resp in cycle 5.
- dfp inputs are not re-sampled outside IDLE. Changes to dfp_addr/dfp_wdata mid-burst have no effect.
- bmem_addr is held constant from the CMD state through the end of the burst.
- Counter wraps to 0 on entry to each CMD state; it never exceeds BEATS-1.

Test Plan:
- Read, ready=1, rvalid beats 0x1111..., 0x2222..., 0x3333..., 0x4444... back-to-back, dfp_addr=0x0000_1234 -> bmem_addr=0x0000_1220, one bmem_read pulse, dfp_resp one cycle with dfp_rdata={0x4444..,0x3333..,0x2222..,0x1111..}.
- Write dfp_addr=0x8000_00E0, wdata words W3..W0, ready=1 -> bmem_write high 4 consecutive cycles with wdata W0,W1,W2,W3, addr 0x8000_00E0, dfp_resp in the 5th cycle after capture.
- bmem_ready=0 for 3 cycles on a read -> bmem_read=0 during the stall, single bmem_read pulse on the ready cycle, no extra commands.
- Read beats with rvalid gaps (pattern 1,0,1,0,0,1,1) -> correct line assembled, dfp_resp only after the 4th valid beat.
- Writeback followed by allocate (dfp_write, dfp_resp, then dfp_read next cycle) -> write burst completes, then read command issued; each transaction yields exactly one dfp_resp.
- rst asserted after 2 read beats -> all outputs 0 next cycle; trailing rvalid beats ignored; next read returns a clean line.

Source files
------------

// File: rtl/cacheline_adapter_if.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_adapter_if
// Purpose  : Cache dfp line port plus bmem burst port, bundled for the adapter.
// Revision : 1.0  initial release
// ============================================================================
interface cacheline_adapter_if #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
);
  // Cache-facing line port
  logic [31:0]        dfp_addr;
  logic               dfp_read;
  logic               dfp_write;
  logic [LINE_W-1:0]  dfp_wdata;
  logic [LINE_W-1:0]  dfp_rdata;
  logic               dfp_resp;

  // Memory-facing burst port
  logic [31:0]        bmem_addr;
  logic               bmem_read;
  logic               bmem_write;
  logic [BURST_W-1:0] bmem_wdata;
  logic               bmem_ready;
  logic [BURST_W-1:0] bmem_rdata;
  logic               bmem_rvalid;

  // master: the environment around the adapter (cache + memory)
  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_rdata, bmem_rvalid
  );

  // slave: the adapter itself
  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_rdata, bmem_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_adapter
// Purpose  : Splits cache line reads/writebacks into 4-beat bmem bursts.
// Revision : 1.0  initial release
// ============================================================================
module cacheline_adapter #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  cacheline_adapter_if.slave   bus
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_CMD  = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_CMD  = 3'd3,
    S_WR_DATA = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t                          r_state;
  logic [CNT_W-1:0]                r_cnt;
  logic [31:0]                     r_addr;
  logic [BEATS-1:0][BURST_W-1:0]   r_buf;

  logic                            w_bmem_read;
  logic                            w_bmem_write;
  logic [BURST_W-1:0]              w_bmem_wdata;
  logic                            w_unused;

  // Byte offset within the line is dropped on capture.
  assign w_unused = ^bus.dfp_addr[OFF_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_buf   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Write wins a simultaneous request; the read stays pending on dfp.
          if (bus.dfp_write) begin
            r_addr  <= {bus.dfp_addr[31:OFF_W], {OFF_W{1'b0}}};
            r_buf   <= bus.dfp_wdata;
            r_cnt   <= '0;
            r_state <= S_WR_CMD;
          end else if (bus.dfp_read) begin
            r_addr  <= {bus.dfp_addr[31:OFF_W], {OFF_W{1'b0}}};
            r_cnt   <= '0;
            r_state <= S_RD_CMD;
          end
        end
        S_RD_CMD: begin
          if (bus.bmem_ready) begin
            r_cnt   <= '0;
            r_state <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (bus.bmem_rvalid) begin
            r_buf[r_cnt] <= bus.bmem_rdata;
            if (r_cnt == c_last_beat) begin
              r_cnt   <= '0;
              r_state <= S_RESP;
            end else begin
              r_cnt <= r_cnt + c_one;
            end
          end
        end
        S_WR_CMD: begin
          if (bus.bmem_ready) begin
            r_cnt   <= c_one;
            r_state <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          // Once beat 0 is accepted the remaining beats stream unconditionally.
          if (r_cnt == c_last_beat) begin
            r_cnt   <= '0;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + c_one;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_bmem_read  = 1'b0;
    w_bmem_write = 1'b0;
    w_bmem_wdata = '0;
    case (r_state)
      S_RD_CMD: begin
        w_bmem_read = bus.bmem_ready;
      end
      S_WR_CMD: begin
        w_bmem_write = bus.bmem_ready;
        w_bmem_wdata = r_buf[0];
      end
      S_WR_DATA: begin
        w_bmem_write = 1'b1;
        w_bmem_wdata = r_buf[r_cnt];
      end
      default: begin
      end
    endcase
  end

  assign bus.bmem_addr  = r_addr;
  assign bus.bmem_read  = w_bmem_read;
  assign bus.bmem_write = w_bmem_write;
  assign bus.bmem_wdata = w_bmem_wdata;
  assign bus.dfp_resp   = (r_state == S_RESP);
  assign bus.dfp_rdata  = r_buf;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cacheline_adapter
// Purpose  : Self-checking bench for cacheline_adapter against a line-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cacheline_adapter;
  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_adapter_if #(.LINE_W(LINE_W), .BURST_W(BURST_W)) bus ();

  cacheline_adapter #(.LINE_W(LINE_W), .BURST_W(BURST_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Observations gathered by the transaction drivers
  logic [LINE_W-1:0]  obs_line;
  logic [BURST_W-1:0] obs_wbeats[$];
  logic [31:0]        obs_addr;
  bit                 obs_addr_seen, obs_addr_var;
  int                 obs_resp_t, obs_n_resp, obs_n_rd, obs_first_t, obs_last_t, obs_spur;
  logic [BURST_W-1:0] exp_beats[4];

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Cycle (relative to the request cycle) of dfp_resp for a read.
  function automatic int read_resp_cycle(int stall, logic [15:0] pat);
    int seen = 0;
    for (int j = 0; j < 16; j++) begin
      if (pat[j]) begin
        seen++;
        if (seen == 4) return stall + 3 + j;
      end
    end
    return -1;
  endfunction

  task automatic obs_clear();
    obs_wbeats.delete();
    obs_line = '0; obs_addr = '0; obs_addr_seen = 0; obs_addr_var = 0;
    obs_resp_t = -1; obs_n_resp = 0; obs_n_rd = 0; obs_first_t = -1; obs_last_t = -1;
  endtask

  task automatic note_addr();
    if (!obs_addr_seen) begin
      obs_addr = bus.bmem_addr;
      obs_addr_seen = 1;
    end else if (bus.bmem_addr !== obs_addr) begin
      obs_addr_var = 1;
    end
  endtask

  // Read line transaction; beats come from exp_beats[], arrival pattern pat.
  task automatic do_read(input logic [31:0] addr, input int stall, input logic [15:0] pat);
    int t, nv, slot;
    bit accepted, done;
    obs_clear();
    @(negedge clk);
    bus.dfp_write = 1'b0; bus.dfp_read = 1'b1; bus.dfp_addr = addr;
    bus.bmem_ready = 1'b0; bus.bmem_rvalid = 1'b0;
    t = 0; nv = 0; slot = 0; accepted = 0; done = 0;
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
      bus.dfp_addr   = $urandom;
      bus.bmem_ready = accepted ? ($urandom_range(0, 1) != 0) : (t > stall);
      if (accepted && nv < 4 && slot < 16) begin
        bus.bmem_rvalid = pat[slot];
        bus.bmem_rdata  = pat[slot] ? exp_beats[nv] : {$urandom, $urandom};
        if (pat[slot]) nv++;
        slot++;
      end else begin
        bus.bmem_rvalid = 1'b0;
        bus.bmem_rdata  = {$urandom, $urandom};
      end
      #1;
      if (bus.bmem_read) begin obs_n_rd++; note_addr(); accepted = 1; end
      if (bus.dfp_resp) begin
        obs_n_resp++; obs_resp_t = t; obs_line = bus.dfp_rdata; done = 1;
      end
    end
  endtask

  // Write line transaction; dfp_read optionally held to model writeback+allocate.
  task automatic do_write(input logic [31:0] addr, input logic [LINE_W-1:0] line,
                          input int stall, input bit also_read);
    int t;
    bit first_seen, done;
    obs_clear();
    @(negedge clk);
    bus.dfp_write = 1'b1; bus.dfp_read = also_read; bus.dfp_addr = addr; bus.dfp_wdata = line;
    bus.bmem_ready = 1'b0; bus.bmem_rvalid = 1'b0;
    t = 0; first_seen = 0; done = 0;
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
      bus.dfp_addr   = $urandom;
      bus.dfp_wdata  = rand_line();
      bus.bmem_ready = first_seen ? ($urandom_range(0, 1) != 0) : (t > stall);
      #1;
      if (bus.bmem_write) begin
        obs_wbeats.push_back(bus.bmem_wdata);
        if (!first_seen) obs_first_t = t;
        first_seen = 1; obs_last_t = t; note_addr();
      end
      if (bus.bmem_read) obs_n_rd++;
      if (bus.dfp_resp) begin obs_n_resp++; obs_resp_t = t; done = 1; end
    end
  endtask

  task automatic idle(input int n);
    obs_spur = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.dfp_read = 1'b0; bus.dfp_write = 1'b0; bus.bmem_ready = 1'b1; bus.bmem_rvalid = 1'b0;
      #1;
      if (bus.dfp_resp || bus.bmem_read || bus.bmem_write) obs_spur++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.dfp_read = 1'b0; bus.dfp_write = 1'b0; bus.dfp_addr = '0; bus.dfp_wdata = '0;
    bus.bmem_ready = 1'b1; bus.bmem_rdata = '0; bus.bmem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.dfp_resp !== 1'b0) begin errors++; $display("FAIL rst_resp: got %b want 0", bus.dfp_resp); end
    checks++; if (bus.bmem_read !== 1'b0) begin errors++; $display("FAIL rst_bmem_read: got %b want 0", bus.bmem_read); end
    checks++; if (bus.bmem_write !== 1'b0) begin errors++; $display("FAIL rst_bmem_write: got %b want 0", bus.bmem_write); end
    checks++; if (bus.bmem_addr !== 32'h0) begin errors++; $display("FAIL rst_bmem_addr: got %h want 0", bus.bmem_addr); end
    checks++; if (bus.bmem_wdata !== '0) begin errors++; $display("FAIL rst_bmem_wdata: got %h want 0", bus.bmem_wdata); end
    checks++; if (bus.dfp_rdata !== '0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus.dfp_rdata); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_read_basic();
    logic [LINE_W-1:0] exp_line;
    exp_beats[0] = 64'h1111_1111_1111_1111; exp_beats[1] = 64'h2222_2222_2222_2222;
    exp_beats[2] = 64'h3333_3333_3333_3333; exp_beats[3] = 64'h4444_4444_4444_4444;
    exp_line = {exp_beats[3], exp_beats[2], exp_beats[1], exp_beats[0]};
    do_read(32'h0000_1234, 0, 16'h000F);
    checks++; if (obs_line !== exp_line) begin errors++; $display("FAIL rd_line: got %h want %h", obs_line, exp_line); end
    checks++; if (obs_addr !== 32'h0000_1220) begin errors++; $display("FAIL rd_addr: got %h want 00001220", obs_addr); end
    checks++; if (obs_n_rd !== 1) begin errors++; $display("FAIL rd_cmds: got %0d want 1", obs_n_rd); end
    checks++; if (obs_resp_t !== 6) begin errors++; $display("FAIL rd_latency: got %0d want 6", obs_resp_t); end
    idle(2);
    checks++; if (obs_spur !== 0) begin errors++; $display("FAIL rd_spurious: got %0d want 0", obs_spur); end
  endtask

  task automatic test_write_basic();
    logic [LINE_W-1:0] line;
    line = rand_line();
    do_write(32'h8000_00E0, line, 0, 1'b0);
    checks++; if (obs_wbeats.size() !== 4) begin errors++; $display("FAIL wr_nbeats: got %0d want 4", obs_wbeats.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (obs_wbeats[i] !== line[i*BURST_W +: BURST_W]) begin
        errors++; $display("FAIL wr_beat%0d: got %h want %h", i, obs_wbeats[i], line[i*BURST_W +: BURST_W]); end
    end
    checks++; if (obs_first_t !== 1 || obs_last_t !== 4) begin errors++; $display("FAIL wr_beat_cycles: got %0d..%0d want 1..4", obs_first_t, obs_last_t); end
    checks++; if (obs_resp_t !== 5) begin errors++; $display("FAIL wr_latency: got %0d want 5", obs_resp_t); end
    checks++; if (obs_addr !== 32'h8000_00E0 || obs_addr_var) begin errors++; $display("FAIL wr_addr: got %h (varied=%0d) want 800000e0", obs_addr, obs_addr_var); end
    idle(2);
    checks++; if (obs_spur !== 0) begin errors++; $display("FAIL wr_spurious: got %0d want 0", obs_spur); end
  endtask

  task automatic test_read_stall();
    logic [31:0] addr;
    addr = $urandom;
    for (int i = 0; i < 4; i++) exp_beats[i] = {$urandom, $urandom};
    do_read(addr, 3, 16'h000F);
    checks++; if (obs_n_rd !== 1) begin errors++; $display("FAIL stall_cmds: got %0d want 1", obs_n_rd); end
    checks++; if (obs_resp_t !== read_resp_cycle(3, 16'h000F)) begin errors++; $display("FAIL stall_latency: got %0d want %0d", obs_resp_t, read_resp_cycle(3, 16'h000F)); end
    checks++; if (obs_line !== {exp_beats[3], exp_beats[2], exp_beats[1], exp_beats[0]}) begin errors++; $display("FAIL stall_line: got %h", obs_line); end
    checks++; if (obs_addr !== {addr[31:5], 5'b0}) begin errors++; $display("FAIL stall_addr: got %h want %h", obs_addr, {addr[31:5], 5'b0}); end
  endtask

  task automatic test_read_gaps();
    for (int i = 0; i < 4; i++) exp_beats[i] = {$urandom, $urandom};
    do_read(32'h0000_4000, 0, 16'b0000_0000_0110_0101);
    checks++; if (obs_line !== {exp_beats[3], exp_beats[2], exp_beats[1], exp_beats[0]}) begin errors++; $display("FAIL gap_line: got %h", obs_line); end
    checks++; if (obs_resp_t !== 9 || obs_n_resp !== 1) begin errors++; $display("FAIL gap_resp: got t=%0d n=%0d want t=9 n=1", obs_resp_t, obs_n_resp); end
  endtask

  task automatic test_back_to_back();
    logic [LINE_W-1:0] line;
    logic [31:0] addr;
    line = rand_line(); addr = $urandom;
    do_write(addr, line, 1, 1'b1);
    checks++; if (obs_n_resp !== 1 || obs_resp_t !== 6) begin errors++; $display("FAIL b2b_wr_resp: got n=%0d t=%0d want n=1 t=6", obs_n_resp, obs_resp_t); end
    checks++; if (obs_n_rd !== 0) begin errors++; $display("FAIL b2b_rd_during_wr: got %0d want 0", obs_n_rd); end
    checks++; if (obs_wbeats.size() !== 4 || obs_wbeats[3] !== line[255:192]) begin errors++; $display("FAIL b2b_wr_beats: got n=%0d", obs_wbeats.size()); end
    for (int i = 0; i < 4; i++) exp_beats[i] = {$urandom, $urandom};
    do_read(addr ^ 32'h0001_0000, 0, 16'h000F);
    checks++; if (obs_n_rd !== 1 || obs_resp_t !== 6 || obs_n_resp !== 1) begin errors++; $display("FAIL b2b_rd: got cmds=%0d t=%0d want 1 6", obs_n_rd, obs_resp_t); end
    checks++; if (obs_line !== {exp_beats[3], exp_beats[2], exp_beats[1], exp_beats[0]}) begin errors++; $display("FAIL b2b_rd_line: got %h", obs_line); end
    idle(1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) exp_beats[i] = {$urandom, $urandom};
    @(negedge clk);
    bus.dfp_read = 1'b1; bus.dfp_addr = 32'h1234_5678; bus.bmem_ready = 1'b1; bus.bmem_rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk); bus.bmem_rvalid = 1'b1; bus.bmem_rdata = exp_beats[0];
    @(negedge clk); bus.bmem_rdata = exp_beats[1];
    @(negedge clk); rst = 1'b1; bus.dfp_read = 1'b0; bus.bmem_rvalid = 1'b0;
    @(negedge clk); rst = 1'b0; bus.bmem_rvalid = 1'b1; bus.bmem_rdata = {$urandom, $urandom};
    #1;
    checks++; if ({bus.dfp_resp, bus.bmem_read, bus.bmem_write} !== 3'b000 || bus.bmem_addr !== 32'h0 || bus.bmem_wdata !== '0 || bus.dfp_rdata !== '0) begin
      errors++; $display("FAIL midrst_outputs: got resp=%b rd=%b wr=%b addr=%h rdata=%h want all 0", bus.dfp_resp, bus.bmem_read, bus.bmem_write, bus.bmem_addr, bus.dfp_rdata); end
    @(negedge clk); bus.bmem_rdata = {$urandom, $urandom};
    #1;
    checks++; if (bus.dfp_resp !== 1'b0 || bus.dfp_rdata !== '0) begin errors++; $display("FAIL midrst_idle_beats: got resp=%b", bus.dfp_resp); end
    bus.bmem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) exp_beats[i] = {$urandom, $urandom};
    do_read(32'h0000_0040, 0, 16'h000F);
    checks++; if (obs_line !== {exp_beats[3], exp_beats[2], exp_beats[1], exp_beats[0]} || obs_resp_t !== 6) begin errors++; $display("FAIL midrst_next_read: got %h t=%0d", obs_line, obs_resp_t); end
    idle(1);
  endtask

  task automatic test_random();
    logic [LINE_W-1:0] line;
    logic [31:0] addr;
    logic [15:0] pat;
    int stall;
    for (int k = 0; k < 8; k++) begin
      addr = $urandom; stall = $urandom_range(0, 4);
      if ($urandom_range(0, 1) != 0) begin
        line = rand_line();
        do_write(addr, line, stall, 1'b0);
        checks++; if (obs_wbeats.size() !== 4 || {obs_wbeats[3], obs_wbeats[2], obs_wbeats[1], obs_wbeats[0]} !== line) begin errors++; $display("FAIL rnd_wr_data[%0d]: got n=%0d", k, obs_wbeats.size()); end
        checks++; if (obs_resp_t !== stall + 5 || obs_first_t !== stall + 1 || obs_last_t !== stall + 4) begin errors++; $display("FAIL rnd_wr_timing[%0d]: got %0d/%0d/%0d want %0d", k, obs_first_t, obs_last_t, obs_resp_t, stall + 5); end
        checks++; if (obs_addr !== {addr[31:5], 5'b0} || obs_addr_var) begin errors++; $display("FAIL rnd_wr_addr[%0d]: got %h want %h", k, obs_addr, {addr[31:5], 5'b0}); end
      end else begin
        do pat = 16'($urandom); while ($countones(pat) < 4);
        for (int i = 0; i < 4; i++) exp_beats[i] = {$urandom, $urandom};
        do_read(addr, stall, pat);
        checks++; if (obs_line !== {exp_beats[3], exp_beats[2], exp_beats[1], exp_beats[0]}) begin errors++; $display("FAIL rnd_rd_line[%0d]: got %h", k, obs_line); end
        checks++; if (obs_resp_t !== read_resp_cycle(stall, pat) || obs_n_rd !== 1) begin errors++; $display("FAIL rnd_rd_timing[%0d]: got t=%0d cmds=%0d want t=%0d", k, obs_resp_t, obs_n_rd, read_resp_cycle(stall, pat)); end
        checks++; if (obs_addr !== {addr[31:5], 5'b0}) begin errors++; $display("FAIL rnd_rd_addr[%0d]: got %h want %h", k, obs_addr, {addr[31:5], 5'b0}); end
      end
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_basic();
    test_read_stall();
    test_read_gaps();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
